// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: PSRAM device model for the controller self-test harness.
// Speaks SPI for the QPI-enable command, then QPI write (0x38), fast read (0xEB)
// and QPI exit (0xF5). Backed by a 2^ADDR_BITS byte array with a registered read port.
module psram_qpi_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 6
) (
    input  logic       i_clkRAM,
    input  logic       reset,
    input  logic       i_psram_sclk,
    input  logic       i_psram_cs,
    input  logic [3:0] i_sio,
    output logic [3:0] o_sio,
    output logic       o_sio_oe,
    output logic       o_qpi,
    output logic       o_err
);

    // Counter must hold both the 8 SPI command bits and the read wait count.
    localparam int CNT_W = $clog2(WAIT_CYCLES + 8);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE,
        SPI_CMD,
        QPI_CMD,
        ADDR,
        WR_DATA,
        RD_WAIT,
        RD_DATA,
        IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic                   sclk_q;
    logic [6:0]             shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   is_read_q, is_read_d;
    logic                   nib_sel_q, nib_sel_d;
    logic [3:0]             hi_nib_q, hi_nib_d;
    logic [3:0]             sio_q, sio_d;
    logic                   oe_q, oe_d;
    logic                   qpi_q, qpi_d;
    logic                   err_q, err_d;

    logic                   rise;
    logic                   fall;
    logic                   we;
    logic [7:0]             wdata;
    logic [7:0]             rd_data_q;
    logic [7:0]             mem [DEPTH];

    assign rise = i_psram_sclk & ~sclk_q;
    assign fall = ~i_psram_sclk & sclk_q;

    assign o_sio    = sio_q;
    assign o_sio_oe = oe_q;
    assign o_qpi    = qpi_q;
    assign o_err    = err_q;

    // Byte array: write on the second data nibble, read continuously at the current address.
    // The read port is always one cycle behind addr_q, which is safe because an SCLK
    // phase spans at least two clocks between an address change and the next fall.
    always_ff @(posedge i_clkRAM) begin
        if (reset && we) begin
            mem[addr_q] <= wdata;
        end
        rd_data_q <= mem[addr_q];
    end

    // Protocol state and output registers.
    always_ff @(posedge i_clkRAM) begin
        if (!reset) begin
            state_q   <= IDLE;
            sclk_q    <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            nib_sel_q <= 1'b0;
            hi_nib_q  <= '0;
            sio_q     <= '0;
            oe_q      <= 1'b0;
            qpi_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= i_psram_sclk;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            is_read_q <= is_read_d;
            nib_sel_q <= nib_sel_d;
            hi_nib_q  <= hi_nib_d;
            sio_q     <= sio_d;
            oe_q      <= oe_d;
            qpi_q     <= qpi_d;
            err_q     <= err_d;
        end
    end

    // Next-state decode; a deasserted chip select overrides everything, including a
    // coincident SCLK rise, so no partial byte or write can leak past CS going high.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        is_read_d = is_read_q;
        nib_sel_d = nib_sel_q;
        hi_nib_d  = hi_nib_q;
        sio_d     = sio_q;
        oe_d      = oe_q;
        qpi_d     = qpi_q;
        err_d     = 1'b0;
        we        = 1'b0;
        wdata     = {hi_nib_q, i_sio};

        if (i_psram_cs) begin
            state_d   = IDLE;
            oe_d      = 1'b0;
            cnt_d     = '0;
            nib_sel_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = qpi_q ? QPI_CMD : SPI_CMD;
                    cnt_d     = '0;
                    nib_sel_d = 1'b0;
                end

                SPI_CMD: begin
                    if (rise) begin
                        shift_d = {shift_q[5:0], i_sio[0]};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d   = '0;
                            state_d = IGNORE;
                            if ({shift_q, i_sio[0]} == 8'h35) begin
                                qpi_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end

                QPI_CMD: begin
                    if (rise) begin
                        shift_d = {shift_q[2:0], i_sio};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            cnt_d = '0;
                            case ({shift_q[3:0], i_sio})
                                8'h38: begin
                                    is_read_d = 1'b0;
                                    state_d   = ADDR;
                                end
                                8'hEB: begin
                                    is_read_d = 1'b1;
                                    state_d   = ADDR;
                                end
                                8'hF5: begin
                                    qpi_d   = 1'b0;
                                    state_d = IGNORE;
                                end
                                default: begin
                                    err_d   = 1'b1;
                                    state_d = IGNORE;
                                end
                            endcase
                        end
                    end
                end

                ADDR: begin
                    if (rise) begin
                        // Shifting through a narrow register keeps only the low address bits.
                        addr_d = ADDR_BITS'({addr_q, i_sio});
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(5)) begin
                            cnt_d     = '0;
                            nib_sel_d = 1'b0;
                            if (!is_read_q) begin
                                state_d = WR_DATA;
                            end else if (WAIT_CYCLES == 0) begin
                                state_d = RD_DATA;
                            end else begin
                                state_d = RD_WAIT;
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (rise) begin
                        if (!nib_sel_q) begin
                            hi_nib_d  = i_sio;
                            nib_sel_d = 1'b1;
                        end else begin
                            we        = 1'b1;
                            nib_sel_d = 1'b0;
                            addr_d    = addr_q + ADDR_BITS'(1);
                        end
                    end
                end

                RD_WAIT: begin
                    if (rise) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                            cnt_d     = '0;
                            nib_sel_d = 1'b0;
                            state_d   = RD_DATA;
                        end
                    end
                end

                RD_DATA: begin
                    if (fall) begin
                        oe_d = 1'b1;
                        if (!nib_sel_q) begin
                            sio_d     = rd_data_q[7:4];
                            nib_sel_d = 1'b1;
                        end else begin
                            sio_d     = rd_data_q[3:0];
                            nib_sel_d = 1'b0;
                            addr_d    = addr_q + ADDR_BITS'(1);
                        end
                    end
                end

                IGNORE: begin
                    state_d = IGNORE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb_psram_qpi_responder: directed bench acting as the PSRAM controller.
// SCLK phases are held for at least two system clocks; DUT outputs are sampled
// on the falling edge of the system clock.
module tb_psram_qpi_responder;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       cs;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic       sio_oe;
    logic       qpi;
    logic       err;

    int         n_checks;
    int         n_fail;
    int         err_cycles;
    logic       oe_seen;
    logic [3:0] nib;
    logic       nib_oe;
    int         err_before;

    psram_qpi_responder #(
        .ADDR_BITS   (10),
        .WAIT_CYCLES (6)
    ) dut (
        .i_clkRAM     (clk),
        .reset        (rst_n),
        .i_psram_sclk (sclk),
        .i_psram_cs   (cs),
        .i_sio        (sio_in),
        .o_sio        (sio_out),
        .o_sio_oe     (sio_oe),
        .o_qpi        (qpi),
        .o_err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every clock cycle with the error strobe high.
    always @(posedge clk) begin
        if (err) err_cycles <= err_cycles + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic cs_start();
        @(negedge clk);
        cs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_end();
        @(negedge clk);
        sclk = 1'b0;
        cs   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One SCLK period carrying nibble d, sampled by the device on the rise.
    task automatic clk_nib(input logic [3:0] d);
        @(negedge clk);
        sclk   = 1'b0;
        sio_in = d;
        repeat (2) @(negedge clk);
        oe_seen = oe_seen | sio_oe;
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        oe_seen = oe_seen | sio_oe;
    endtask

    // One SCLK period of a read: capture the nibble driven after the fall.
    task automatic rd_nib(output logic [3:0] n, output logic oe);
        @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        n    = sio_out;
        oe   = sio_oe;
        sclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        cs_start();
        for (int i = 7; i >= 0; i--) begin
            clk_nib({3'b101, b[i]});
        end
        cs_end();
    endtask

    task automatic qpi_byte(input logic [7:0] b);
        clk_nib(b[7:4]);
        clk_nib(b[3:0]);
    endtask

    task automatic qpi_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) begin
            clk_nib(a[i*4 +: 4]);
        end
    endtask

    task automatic start_read(input logic [23:0] a);
        cs_start();
        qpi_byte(8'hEB);
        qpi_addr(a);
        for (int i = 0; i < 6; i++) clk_nib(4'h0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        err_cycles = 0;
        oe_seen    = 1'b0;
        rst_n      = 1'b0;
        cs         = 1'b1;
        sclk       = 1'b0;
        sio_in     = 4'h0;
        repeat (3) @(negedge clk);

        check("reset_qpi", {31'd0, qpi}, 32'd0);
        check("reset_oe", {31'd0, sio_oe}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_sio", {28'd0, sio_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SPI 0x35 enables QPI; upper data lines carry junk that must be ignored.
        oe_seen    = 1'b0;
        err_before = err_cycles;
        spi_byte(8'h35);
        check("qpi_enable", {31'd0, qpi}, 32'd1);
        check("qpi_enable_no_drive", {31'd0, oe_seen}, 32'd0);
        check("qpi_enable_no_err", err_cycles - err_before, 32'd0);

        // Write 0xF0 to 0x00AAAA (array index 0x2AA), then read it back.
        cs_start();
        qpi_byte(8'h38);
        qpi_addr(24'h00AAAA);
        qpi_byte(8'hF0);
        cs_end();
        start_read(24'h00AAAA);
        rd_nib(nib, nib_oe);
        check("rd_2aa_hi", {28'd0, nib}, 32'hF);
        check("rd_2aa_hi_oe", {31'd0, nib_oe}, 32'd1);
        rd_nib(nib, nib_oe);
        check("rd_2aa_lo", {28'd0, nib}, 32'h0);
        check("rd_2aa_lo_oe", {31'd0, nib_oe}, 32'd1);
        cs_end();
        check("oe_release", {31'd0, sio_oe}, 32'd0);

        // Burst write across the top of the array, then read across the wrap.
        cs_start();
        qpi_byte(8'h38);
        qpi_addr(24'h0003FF);
        qpi_byte(8'h11);
        qpi_byte(8'h22);
        cs_end();
        start_read(24'h0003FF);
        rd_nib(nib, nib_oe);
        check("burst_0", {28'd0, nib}, 32'h1);
        rd_nib(nib, nib_oe);
        check("burst_1", {28'd0, nib}, 32'h1);
        rd_nib(nib, nib_oe);
        check("burst_2", {28'd0, nib}, 32'h2);
        rd_nib(nib, nib_oe);
        check("burst_3", {28'd0, nib}, 32'h2);
        cs_end();
        start_read(24'h000000);
        rd_nib(nib, nib_oe);
        check("wrap_idx0_hi", {28'd0, nib}, 32'h2);
        rd_nib(nib, nib_oe);
        check("wrap_idx0_lo", {28'd0, nib}, 32'h2);
        cs_end();

        // Abort a write after one nibble; memory must keep 0xF0.
        cs_start();
        qpi_byte(8'h38);
        qpi_addr(24'h00AAAA);
        clk_nib(4'h5);
        cs_end();
        start_read(24'h00AAAA);
        rd_nib(nib, nib_oe);
        check("abort_hi", {28'd0, nib}, 32'hF);
        rd_nib(nib, nib_oe);
        check("abort_lo", {28'd0, nib}, 32'h0);
        cs_end();

        // Unsupported QPI command: single error cycle and no drive.
        err_before = err_cycles;
        oe_seen    = 1'b0;
        cs_start();
        qpi_byte(8'h9F);
        for (int i = 0; i < 8; i++) clk_nib(4'h0);
        cs_end();
        check("bad_cmd_err_cycles", err_cycles - err_before, 32'd1);
        check("bad_cmd_no_drive", {31'd0, oe_seen}, 32'd0);
        check("bad_cmd_qpi_kept", {31'd0, qpi}, 32'd1);

        // QPI exit, then SPI re-enable.
        cs_start();
        qpi_byte(8'hF5);
        cs_end();
        check("qpi_exit", {31'd0, qpi}, 32'd0);
        spi_byte(8'h35);
        check("qpi_reenable", {31'd0, qpi}, 32'd1);

        // Reset in the middle of a read burst.
        start_read(24'h0003FF);
        rd_nib(nib, nib_oe);
        check("pre_reset_oe", {31'd0, nib_oe}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_oe", {31'd0, sio_oe}, 32'd0);
        check("mid_reset_qpi", {31'd0, qpi}, 32'd0);
        cs   = 1'b1;
        sclk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        spi_byte(8'h35);
        check("post_reset_spi_enable", {31'd0, qpi}, 32'd1);
        start_read(24'h00AAAA);
        rd_nib(nib, nib_oe);
        check("post_reset_mem_hi", {28'd0, nib}, 32'hF);
        rd_nib(nib, nib_oe);
        check("post_reset_mem_lo", {28'd0, nib}, 32'h0);
        cs_end();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
